// File: rtl/ebi_initiator_if.sv
// ebi_initiator_if -- command/response and external-bus signals of ebi_initiator.
//   Command side : cmd_valid, cmd_ready, cmd_write, cmd_addr[18:0], cmd_wdata[15:0]
//   Response side: rsp_valid, rsp_rdata[15:0], busy
//   External bus : ebi_cs_n, ebi_wr_n, ebi_rd_n, ebi_addr[18:0],
//                  ebi_data_out[15:0], ebi_data_oe, ebi_data_in[15:0]
// modport master: the initiator (drives the bus, accepts commands).
// modport slave : the command source plus the external memory/peripheral.
interface ebi_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [18:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        ebi_cs_n;
  logic        ebi_wr_n;
  logic        ebi_rd_n;
  logic [18:0] ebi_addr;
  logic [15:0] ebi_data_out;
  logic        ebi_data_oe;
  logic [15:0] ebi_data_in;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, ebi_data_in,
    output cmd_ready, rsp_valid, rsp_rdata, busy,
           ebi_cs_n, ebi_wr_n, ebi_rd_n, ebi_addr, ebi_data_out, ebi_data_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, ebi_data_in,
    input  cmd_ready, rsp_valid, rsp_rdata, busy,
           ebi_cs_n, ebi_wr_n, ebi_rd_n, ebi_addr, ebi_data_out, ebi_data_oe
  );
endinterface

// File: rtl/ebi_initiator.sv
// ebi_initiator -- asynchronous external-bus initiator. Each command runs
// IDLE -> SETUP -> STROBE -> HOLD -> TURN -> IDLE with programmable phase lengths.
// Parameters: SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES (each 1..15).
// Ports:
//   sys_clk : system clock, rising edge
//   reset   : synchronous, active-high
//   bus     : ebi_initiator_if.master (command, response and bus pins)
// Build option: define EBI_INITIATOR_CMD_FIFO_EN for a 4-entry command FIFO
// (cmd_ready = not full); otherwise commands are taken only in IDLE.
module ebi_initiator #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  ebi_initiator_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

  // Counters load "length - 1" and leave the phase when they reach zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic        r_cs_n, r_wr_n, r_rd_n, r_oe, r_rsp_valid;
  logic [18:0] r_addr;
  logic [15:0] r_dout, r_rdata;

  logic        w_ready, w_cmd_avail, w_cmd_write, w_queued;
  logic [18:0] w_cmd_addr;
  logic [15:0] w_cmd_wdata;

`ifdef EBI_INITIATOR_CMD_FIFO_EN
  logic [35:0] r_fifo [4];
  logic [1:0]  r_wptr, r_rptr;
  logic [2:0]  r_count;
  logic        w_push, w_pop;

  assign w_ready     = (r_count != 3'd4);
  assign w_push      = bus.cmd_valid & w_ready;
  assign w_pop       = (r_state == IDLE) && (r_count != 3'd0);
  assign w_cmd_avail = (r_count != 3'd0);
  assign w_queued    = (r_count != 3'd0);
  assign {w_cmd_write, w_cmd_addr, w_cmd_wdata} = r_fifo[r_rptr];

  always_ff @(posedge sys_clk) begin
    if (w_push) r_fifo[r_wptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    if (reset) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (!w_push && w_pop) r_count <= r_count - 3'd1;
    end
  end
`else
  assign w_ready     = (r_state == IDLE);
  assign w_cmd_avail = bus.cmd_valid;
  assign w_cmd_write = bus.cmd_write;
  assign w_cmd_addr  = bus.cmd_addr;
  assign w_cmd_wdata = bus.cmd_wdata;
  assign w_queued    = 1'b0;
`endif

  // All bus outputs are registered and only change on phase transitions.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_cs_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmd_avail) begin
            r_state <= SETUP;
            r_cnt   <= SETUP_LD;
            r_write <= w_cmd_write;
            r_cs_n  <= 1'b0;
            r_addr  <= w_cmd_addr;
            if (w_cmd_write) begin
              r_oe   <= 1'b1;
              r_dout <= w_cmd_wdata;
            end
          end
        end
        SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state <= STROBE;
            r_cnt   <= STROBE_LD;
            if (r_write) r_wr_n <= 1'b0;
            else         r_rd_n <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state <= HOLD;
            r_cnt   <= HOLD_LD;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            // Sample read data on the edge that closes the strobe.
            if (!r_write) begin
              r_rdata     <= bus.ebi_data_in;
              r_rsp_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (r_cnt == 4'd0) begin
            r_state <= TURN;
            r_cs_n  <= 1'b1;
            r_oe    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        TURN:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = w_ready;
  assign bus.busy         = (r_state != IDLE) | w_queued;
  assign bus.ebi_cs_n     = r_cs_n;
  assign bus.ebi_wr_n     = r_wr_n;
  assign bus.ebi_rd_n     = r_rd_n;
  assign bus.ebi_addr     = r_addr;
  assign bus.ebi_data_out = r_dout;
  assign bus.ebi_data_oe  = r_oe;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rdata;

endmodule

// File: tb/tb_ebi_initiator.sv
// tb_ebi_initiator -- self-checking bench for ebi_initiator.
// Two instances: u_dut0 with default timing (1/3/1) and u_dut1 with 2/1/3.
// Expected pin activity is derived from phase boundaries computed from the
// parameters; read data is tracked per instance in last_rd.
module tb_ebi_initiator;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic reset;

`ifdef EBI_INITIATOR_CMD_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  ebi_initiator_if if0 ();
  ebi_initiator_if if1 ();

  ebi_initiator #(.SETUP_CYCLES(1), .STROBE_CYCLES(3), .HOLD_CYCLES(1))
    u_dut0 (.sys_clk(sys_clk), .reset(reset), .bus(if0));
  ebi_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3))
    u_dut1 (.sys_clk(sys_clk), .reset(reset), .bus(if1));

  logic        sel, t_valid, t_write;
  logic [18:0] t_addr;
  logic [15:0] t_wdata, t_din;

  assign if0.cmd_valid   = t_valid & ~sel;
  assign if1.cmd_valid   = t_valid & sel;
  assign if0.cmd_write   = t_write;
  assign if1.cmd_write   = t_write;
  assign if0.cmd_addr    = t_addr;
  assign if1.cmd_addr    = t_addr;
  assign if0.cmd_wdata   = t_wdata;
  assign if1.cmd_wdata   = t_wdata;
  assign if0.ebi_data_in = t_din;
  assign if1.ebi_data_in = t_din;

  logic        m_ready, m_busy, m_cs_n, m_wr_n, m_rd_n, m_oe, m_rsp;
  logic [18:0] m_addr;
  logic [15:0] m_dout, m_rdata;
  assign m_ready = sel ? if1.cmd_ready    : if0.cmd_ready;
  assign m_busy  = sel ? if1.busy         : if0.busy;
  assign m_cs_n  = sel ? if1.ebi_cs_n     : if0.ebi_cs_n;
  assign m_wr_n  = sel ? if1.ebi_wr_n     : if0.ebi_wr_n;
  assign m_rd_n  = sel ? if1.ebi_rd_n     : if0.ebi_rd_n;
  assign m_oe    = sel ? if1.ebi_data_oe  : if0.ebi_data_oe;
  assign m_rsp   = sel ? if1.rsp_valid    : if0.rsp_valid;
  assign m_addr  = sel ? if1.ebi_addr     : if0.ebi_addr;
  assign m_dout  = sel ? if1.ebi_data_out : if0.ebi_data_out;
  assign m_rdata = sel ? if1.rsp_rdata    : if0.rsp_rdata;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] last_rd [2];
  int stall_at;

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chkw(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // One command on the selected instance, checked cycle by cycle.
  task automatic do_txn(input logic s, input logic w, input logic [18:0] a,
                        input logic [15:0] wd, input logic [15:0] din,
                        output int cs_lo, output int wr_lo, output int rd_lo,
                        output int rsp_n, output int len);
    int sc, st, hc, guard, total, j;
    logic p_set, p_stb, p_hold, p_act, seen_cs, done;
    sc = s ? 2 : 1; st = s ? 1 : 3; hc = s ? 3 : 1;
    cs_lo = 0; wr_lo = 0; rd_lo = 0; rsp_n = 0; len = 0;
    seen_cs = 1'b0; done = 1'b0; guard = 0;
    sel = s; t_write = w; t_addr = a; t_wdata = wd; t_din = ~din; t_valid = 1'b1;
    @(negedge sys_clk);
    while (!m_ready) begin
      guard++;
      if (guard > 50) begin
        chkb("accept_timeout", 1'b0, 1'b1);
        t_valid = 1'b0;
        return;
      end
      @(negedge sys_clk);
    end
    @(posedge sys_clk); #1;
    t_valid = 1'b0;
    total = LAT + sc + st + hc + 2;
    for (int k = 0; k < total; k++) begin
      j      = k - LAT;
      p_set  = (j >= 0) && (j < sc);
      p_stb  = (j >= sc) && (j < sc + st);
      p_hold = (j >= sc + st) && (j < sc + st + hc);
      p_act  = p_set | p_stb | p_hold;
      t_din  = p_stb ? din : ~din;
      @(negedge sys_clk);
      if (!w && j == sc + st) last_rd[s] = din;
      chkb("cs_n", m_cs_n, !p_act);
      chkb("wr_n", m_wr_n, !(p_stb && w));
      chkb("rd_n", m_rd_n, !(p_stb && !w));
      chkb("data_oe", m_oe, p_act && w);
      chkb("rsp_valid", m_rsp, !w && (j == sc + st));
      chkb("busy", m_busy, k < LAT + sc + st + hc + 1);
      chkw("rsp_rdata", 32'(m_rdata), 32'(last_rd[s]));
      if (p_act) chkw("ebi_addr", 32'(m_addr), 32'(a));
      if (p_act && w) chkw("data_out", 32'(m_dout), 32'(wd));
      if (!m_cs_n) begin cs_lo++; seen_cs = 1'b1; end
      if (!m_wr_n) wr_lo++;
      if (!m_rd_n) rd_lo++;
      if (m_rsp) rsp_n++;
      if (seen_cs && !done) begin
        len++;
        if (!m_busy) done = 1'b1;
      end
      @(posedge sys_clk); #1;
    end
  endtask

  // Pushes n writes (addr 0x100+i) on u_dut0 as fast as cmd_ready allows.
  task automatic push_seq(input int n, output int stall);
    int acc, guard;
    acc = 0; guard = 0; stall = -1;
    sel = 1'b0; t_write = 1'b1;
    while (acc < n && guard < 300) begin
      t_addr = 19'h100 + 19'(acc); t_wdata = 16'(acc); t_valid = 1'b1;
      @(negedge sys_clk); guard++;
      if (m_ready) acc++;
      else if (stall < 0) stall = acc;
      @(posedge sys_clk); #1;
    end
    t_valid = 1'b0;
    chkw("push_done", 32'(acc), 32'(n));
  endtask

  // Watches u_dut0's bus: transactions in order, TURN+IDLE between them.
  task automatic watch(input int n);
    int seen, gap, guard;
    logic prev;
    seen = 0; gap = 0; guard = 0; prev = 1'b1;
    while (seen < n && guard < 400) begin
      @(negedge sys_clk); guard++;
      if (prev && !if0.ebi_cs_n) begin
        chkw("order_addr", 32'(if0.ebi_addr), 32'h100 + 32'(seen));
        if (seen > 0) chkw("idle_gap", 32'(gap), 32'd2);
        seen++; gap = 0;
      end
      if (if0.ebi_cs_n) gap++;
      prev = if0.ebi_cs_n;
    end
    chkw("txn_count", 32'(seen), 32'(n));
  endtask

  typedef struct {
    logic        s;
    logic        w;
    logic [18:0] a;
    logic [15:0] wd;
    logic [15:0] din;
    int          e_cs, e_wr, e_rd, e_rsp, e_len;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int cs_lo, wr_lo, rd_lo, rsp_n, len;
    tbl[0] = '{1'b0, 1'b1, 19'h00032, 16'hA5A5, 16'h0000, 5, 3, 0, 0, 7};
    tbl[1] = '{1'b0, 1'b0, 19'h00032, 16'h0000, 16'h1234, 5, 0, 3, 1, 7};
    tbl[2] = '{1'b0, 1'b1, 19'h7FFFF, 16'hFFFF, 16'h0000, 5, 3, 0, 0, 7};
    tbl[3] = '{1'b0, 1'b0, 19'h00000, 16'h0000, 16'hFFFF, 5, 0, 3, 1, 7};
    tbl[4] = '{1'b1, 1'b1, 19'h12345, 16'h5A5A, 16'h0000, 6, 1, 0, 0, 8};
    tbl[5] = '{1'b1, 1'b0, 19'h40001, 16'h0000, 16'hBEEF, 6, 0, 1, 1, 8};

    sel = 1'b0; t_valid = 1'b0; t_write = 1'b0; t_addr = '0; t_wdata = '0; t_din = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;

    @(negedge sys_clk);
    chkb("rst_cs_n", if0.ebi_cs_n, 1'b1);
    chkb("rst_wr_n", if0.ebi_wr_n, 1'b1);
    chkb("rst_rd_n", if0.ebi_rd_n, 1'b1);
    chkb("rst_oe", if0.ebi_data_oe, 1'b0);
    chkw("rst_addr", 32'(if0.ebi_addr), 32'd0);
    chkw("rst_dout", 32'(if0.ebi_data_out), 32'd0);
    chkb("rst_rsp", if0.rsp_valid, 1'b0);
    chkw("rst_rdata", 32'(if0.rsp_rdata), 32'd0);
    chkb("rst_busy", if0.busy, 1'b0);
    chkb("rst_ready", if0.cmd_ready, 1'b1);
    chkb("rst_cs_n_1", if1.ebi_cs_n, 1'b1);
    @(posedge sys_clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_txn(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].din,
             cs_lo, wr_lo, rd_lo, rsp_n, len);
      chkw("tbl_cs_cycles", 32'(cs_lo), 32'(tbl[i].e_cs));
      chkw("tbl_wr_cycles", 32'(wr_lo), 32'(tbl[i].e_wr));
      chkw("tbl_rd_cycles", 32'(rd_lo), 32'(tbl[i].e_rd));
      chkw("tbl_rsp_pulses", 32'(rsp_n), 32'(tbl[i].e_rsp));
      chkw("tbl_txn_len", 32'(len), 32'(tbl[i].e_len));
      if (!tbl[i].w) chkw("tbl_rdata", 32'(m_rdata), 32'(tbl[i].din));
    end

    for (int r = 0; r < 24; r++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 19'($urandom),
             16'($urandom), 16'($urandom), cs_lo, wr_lo, rd_lo, rsp_n, len);
    end

    // Back-to-back commands: one IDLE between TURN and the next SETUP.
    fork
      push_seq(2, stall_at);
      watch(2);
    join
    repeat (10) @(posedge sys_clk);
    #1;

`ifdef EBI_INITIATOR_CMD_FIFO_EN
    fork
      push_seq(6, stall_at);
      watch(6);
    join
    chkw("fifo_accepts_before_stall", 32'(stall_at), 32'd5);
    repeat (10) @(posedge sys_clk);
    #1;
`endif

    // Reset in the second STROBE cycle of a read aborts it.
    sel = 1'b0; t_write = 1'b0; t_addr = 19'h00555; t_din = 16'h7777; t_valid = 1'b1;
    @(negedge sys_clk);
    chkb("abort_ready", m_ready, 1'b1);
    @(posedge sys_clk); #1;
    t_valid = 1'b0;
    repeat (LAT + 2) begin @(posedge sys_clk); #1; end
    @(negedge sys_clk);
    chkb("abort_pre_rd_n", m_rd_n, 1'b0);
    reset = 1'b1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge sys_clk);
    chkb("abort_cs_n", m_cs_n, 1'b1);
    chkb("abort_rd_n", m_rd_n, 1'b1);
    chkb("abort_busy", m_busy, 1'b0);
    chkb("abort_rsp", m_rsp, 1'b0);
    chkw("abort_rdata", 32'(m_rdata), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      chkb("abort_no_rsp", m_rsp, 1'b0);
      chkb("abort_cs_idle", m_cs_n, 1'b1);
    end
    @(posedge sys_clk); #1;

    do_txn(1'b0, 1'b0, 19'h0ABCD, 16'h0000, 16'hC3C3, cs_lo, wr_lo, rd_lo, rsp_n, len);
    chkw("post_reset_rdata", 32'(m_rdata), 32'h0000C3C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
